disp_scan_mux: RTL and testbench



---
 rtl/disp_pkg.sv | 18 +
 rtl/disp_scan_mux_hex7seg.sv | 12 +
 rtl/disp_scan_mux.sv | 105 ++++++++++
 tb/tb_disp_scan_mux.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared seven-segment definitions for the display path.
// The scanner and the number decoders both use this pattern table.
package disp_pkg;

  // Segment patterns for hex digits 0-F, bit 0 = segment a, bit 6 = segment g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

endpackage

// File: rtl/disp_scan_mux_hex7seg.sv
// Combinational hex to seven-segment decoder.
// The pattern table lives in disp_pkg so other decoders can share it.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[val_i];

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed seven-segment scanner with per-frame input snapshot,
// a dark interval at each digit change, and a registered output stage.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int N_DIGITS   = 2,
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digit_val,
  input  logic [N_DIGITS-1:0]   digit_blank,
  input  logic [N_DIGITS-1:0]   dp,
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  phase_e                phase_q, phase_d;
  logic [4*N_DIGITS-1:0] shadowVal_q, shadowVal_d;
  logic [N_DIGITS-1:0]   shadowBlank_q, shadowBlank_d;
  logic [N_DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [7:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frameTick_q, frameTick_d;

  logic                  cntWrap;
  logic                  frameStart;
  logic [3:0]            curVal;
  logic [6:0]            curPattern;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      phase_q       <= PH_BLANK;
      shadowVal_q   <= '0;
      shadowBlank_q <= '1;
      shadowDp_q    <= '0;
      seg_q         <= SEG_OFF;
      an_q          <= '0;
      frameTick_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      shadowVal_q   <= shadowVal_d;
      shadowBlank_q <= shadowBlank_d;
      shadowDp_q    <= shadowDp_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frameTick_q   <= frameTick_d;
    end
  end

  // The shadow is bypassed during the snapshot cycle so digit 0 never shows
  // stale data when there is no blank interval.
  always_comb begin
    cntWrap    = (cnt_q == CNT_LAST);
    frameStart = (cnt_q == '0) && (idx_q == '0);

    cnt_d = cntWrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cntWrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    phase_d = (int'(cnt_d) < BLANK_CYC) ? PH_BLANK : PH_DRIVE;

    shadowVal_d   = frameStart ? digit_val   : shadowVal_q;
    shadowBlank_d = frameStart ? digit_blank : shadowBlank_q;
    shadowDp_d    = frameStart ? dp          : shadowDp_q;

    curVal = shadowVal_d[int'(idx_q) * 4 +: 4];
  end

  hex7seg u_hex7seg (
    .val_i (curVal),
    .seg_o (curPattern)
  );

  always_comb begin
    an_d        = '0;
    seg_d       = SEG_OFF;
    frameTick_d = cntWrap && (idx_q == IDX_LAST);
    if ((phase_q == PH_DRIVE) && !shadowBlank_d[idx_q]) begin
      an_d[idx_q] = 1'b1;
      seg_d       = {shadowDp_d[idx_q], curPattern};
    end
  end

  assign seg        = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign an         = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux: a 2-digit active-high scanner and a
// 4-digit active-low scanner with no blank interval.
module tb_disp_scan_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstA;
  logic [7:0]  valA;
  logic [1:0]  blankA, dpA;
  logic [7:0]  segA;
  logic [1:0]  anA;
  logic        tickA;

  logic        rstB;
  logic [15:0] valB;
  logic [3:0]  blankB, dpB;
  logic [7:0]  segB;
  logic [3:0]  anB;
  logic        tickB;

  int checks = 0;
  int errors = 0;
  int edgeA  = 0;
  int edgeB  = 0;

  logic [6:0] pat [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  disp_scan_mux #(.N_DIGITS(2), .CLK_DIV(4), .BLANK_CYC(1), .ACTIVE_LOW(0)) dutA (
    .clk(clk), .rst(rstA), .digit_val(valA), .digit_blank(blankA), .dp(dpA),
    .seg(segA), .an(anA), .frame_tick(tickA)
  );

  disp_scan_mux #(.N_DIGITS(4), .CLK_DIV(3), .BLANK_CYC(0), .ACTIVE_LOW(1)) dutB (
    .clk(clk), .rst(rstB), .digit_val(valB), .digit_blank(blankB), .dp(dpB),
    .seg(segB), .an(anB), .frame_tick(tickB)
  );

  // Advance one clock and sample just after the edge.
  task automatic stepCycle;
    @(posedge clk);
    #1;
    edgeA++;
    edgeB++;
  endtask

  // Expected DUT A outputs after the n-th edge following reset release.
  task automatic modelA(input int n, input logic [7:0] v, input logic [1:0] bl,
                        input logic [1:0] d, output logic [1:0] eAn,
                        output logic [7:0] eSeg, output logic eTick);
    int pos, digit;
    pos   = (n - 1) % 8;
    digit = pos / 4;
    eAn   = '0;
    eSeg  = 8'h00;
    eTick = (pos == 7);
    if ((pos % 4) != 0 && !bl[digit]) begin
      eAn[digit] = 1'b1;
      eSeg       = {d[digit], pat[v[4*digit +: 4]]};
    end
  endtask

  task automatic test_reset;
    logic [1:0] eAn;
    logic [7:0] eSeg;
    logic       eTick;
    rstA = 1'b1; valA = 8'h31; blankA = 2'b00; dpA = 2'b00;
    repeat (3) stepCycle();
    checks++;
    if (anA !== 2'b00) begin errors++; $display("[TB] FAIL reset_an: got %b expected 00", anA); end
    checks++;
    if (segA !== 8'h00) begin errors++; $display("[TB] FAIL reset_seg: got %h expected 00", segA); end
    checks++;
    if (tickA !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick: got %b expected 0", tickA); end
    @(negedge clk);
    rstA  = 1'b0;
    edgeA = 0;
    for (int i = 0; i < 16; i++) begin
      stepCycle();
      modelA(edgeA, 8'h31, 2'b00, 2'b00, eAn, eSeg, eTick);
      checks++;
      if (anA !== eAn || segA !== eSeg || tickA !== eTick) begin
        errors++;
        $display("[TB] FAIL scan_edge%0d: got an=%b seg=%h tick=%b expected an=%b seg=%h tick=%b",
                 edgeA, anA, segA, tickA, eAn, eSeg, eTick);
      end
    end
  endtask

  task automatic test_no_tear;
    logic [1:0] eAn;
    logic [7:0] eSeg;
    logic       eTick;
    for (int i = 0; i < 16; i++) begin
      stepCycle();
      modelA(edgeA, (i < 8) ? 8'h31 : 8'h70, 2'b00, 2'b00, eAn, eSeg, eTick);
      checks++;
      if (anA !== eAn || segA !== eSeg || tickA !== eTick) begin
        errors++;
        $display("[TB] FAIL no_tear_edge%0d: got an=%b seg=%h tick=%b expected an=%b seg=%h tick=%b",
                 edgeA, anA, segA, tickA, eAn, eSeg, eTick);
      end
      if (i == 4) valA = 8'h70;
    end
  endtask

  task automatic test_blank_dp;
    logic [1:0] eAn;
    logic [7:0] eSeg;
    logic       eTick;
    blankA = 2'b10; dpA = 2'b01; valA = 8'h31;
    for (int i = 0; i < 16; i++) begin
      stepCycle();
      modelA(edgeA, 8'h31, 2'b10, 2'b01, eAn, eSeg, eTick);
      checks++;
      if (anA !== eAn || segA !== eSeg || tickA !== eTick) begin
        errors++;
        $display("[TB] FAIL blank_dp_edge%0d: got an=%b seg=%h tick=%b expected an=%b seg=%h tick=%b",
                 edgeA, anA, segA, tickA, eAn, eSeg, eTick);
      end
    end
    checks++;
    if (segA !== 8'h00) begin errors++; $display("[TB] FAIL blank_slot_seg: got %h expected 00", segA); end
  endtask

  task automatic test_frame_tick;
    int ticks = 0;
    int misaligned = 0;
    int multiHot = 0;
    for (int i = 0; i < 1000; i++) begin
      stepCycle();
      if (tickA === 1'b1) ticks++;
      if (tickA !== (((edgeA - 1) % 8) == 7)) misaligned++;
      if ($countones(anA) > 1) multiHot++;
    end
    checks++;
    if (ticks != 125) begin errors++; $display("[TB] FAIL tick_count: got %0d expected 125", ticks); end
    checks++;
    if (misaligned != 0) begin errors++; $display("[TB] FAIL tick_align: got %0d bad cycles expected 0", misaligned); end
    checks++;
    if (multiHot != 0) begin errors++; $display("[TB] FAIL an_onehot: got %0d multi-hot cycles expected 0", multiHot); end
  endtask

  task automatic test_async_reset;
    logic [1:0] eAn;
    logic [7:0] eSeg;
    logic       eTick;
    repeat (3) stepCycle();
    checks++;
    if (anA !== 2'b01 || segA !== 8'h86) begin
      errors++;
      $display("[TB] FAIL pre_reset_lit: got an=%b seg=%h expected an=01 seg=86", anA, segA);
    end
    #2 rstA = 1'b1;
    #1;
    checks++;
    if (anA !== 2'b00 || segA !== 8'h00 || tickA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_off: got an=%b seg=%h tick=%b expected an=00 seg=00 tick=0",
               anA, segA, tickA);
    end
    valA = 8'h52; blankA = 2'b00; dpA = 2'b00;
    stepCycle();
    @(negedge clk);
    rstA  = 1'b0;
    edgeA = 0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      modelA(edgeA, 8'h52, 2'b00, 2'b00, eAn, eSeg, eTick);
      checks++;
      if (anA !== eAn || segA !== eSeg || tickA !== eTick) begin
        errors++;
        $display("[TB] FAIL restart_edge%0d: got an=%b seg=%h tick=%b expected an=%b seg=%h tick=%b",
                 edgeA, anA, segA, tickA, eAn, eSeg, eTick);
      end
    end
  endtask

  task automatic test_active_low;
    logic [3:0] eAn;
    logic [7:0] eSeg;
    logic       eTick;
    int         pos, digit;
    checks++;
    if (anB !== 4'hF || segB !== 8'hFF || tickB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL al_reset: got an=%b seg=%h tick=%b expected an=1111 seg=ff tick=0",
               anB, segB, tickB);
    end
    @(negedge clk);
    rstB  = 1'b0;
    edgeB = 0;
    for (int i = 0; i < 36; i++) begin
      stepCycle();
      if (edgeB >= 13) begin
        pos   = (edgeB - 1) % 12;
        digit = pos / 3;
        eAn   = ~(4'b0001 << digit);
        eSeg  = ~{1'b0, pat[valB[4*digit +: 4]]};
        eTick = (pos == 11);
        checks++;
        if (anB !== eAn || segB !== eSeg || tickB !== eTick) begin
          errors++;
          $display("[TB] FAIL al_scan_edge%0d: got an=%b seg=%h tick=%b expected an=%b seg=%h tick=%b",
                   edgeB, anB, segB, tickB, eAn, eSeg, eTick);
        end
      end
    end
  endtask

  initial begin
    rstB = 1'b1; valB = 16'hFEDC; blankB = 4'h0; dpB = 4'h0;
    test_reset();
    test_no_tear();
    test_blank_dp();
    test_frame_tick();
    test_async_reset();
    test_active_low();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
